// File: rtl/ofmap_writer_pkg.sv
// rtl/ofmap_writer_pkg.sv - shared FSM state type and params_dat field layout
package ofmap_writer_pkg;

  typedef enum logic [1:0] {IDLE, STREAM, DONE} state_t;

  // Field index within params_dat; slice offset = index * PARAM_WID.
  localparam int OY0_FIELD = 0;
  localparam int OC1_FIELD = 1;
  localparam int OY1_FIELD = 2;

endpackage

// File: rtl/ofmap_stream_writer_if.sv
// rtl/ofmap_stream_writer_if.sv - config, ofmap stream and SRAM write signals
interface ofmap_stream_writer_if #(
  parameter int PARAM_WID = 16,
  parameter int ADDR_WID  = 32
);
  logic [3*PARAM_WID-1:0] params_dat;
  logic                   params_vld;
  logic                   params_rdy;
  logic [31:0]            ofmap_dat;
  logic                   ofmap_vld;
  logic                   ofmap_rdy;
  logic                   mem_wen;
  logic [ADDR_WID-1:0]    mem_waddr;
  logic [31:0]            mem_wdata;
  logic                   layer_done;
  logic                   busy;

  modport slave (
    input  params_dat, params_vld, ofmap_dat, ofmap_vld,
    output params_rdy, ofmap_rdy, mem_wen, mem_waddr, mem_wdata, layer_done, busy
  );

  modport master (
    output params_dat, params_vld, ofmap_dat, ofmap_vld,
    input  params_rdy, ofmap_rdy, mem_wen, mem_waddr, mem_wdata, layer_done, busy
  );
endinterface

// File: rtl/ofmap_addr_gen.sv
// rtl/ofmap_addr_gen.sv - six-digit tile counter nest and linear channel-major address
module ofmap_addr_gen #(
  parameter int OC0       = 4,
  parameter int PARAM_WID = 16,
  parameter int ADDR_WID  = 32
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clear,
  input  logic                 adv,
  input  logic [PARAM_WID-1:0] cfg_oy1,
  input  logic [PARAM_WID-1:0] cfg_oc1,
  input  logic [PARAM_WID-1:0] cfg_oy0,
  input  logic [ADDR_WID-1:0]  oy,
  input  logic [ADDR_WID-1:0]  plane,
  output logic [ADDR_WID-1:0]  addr,
  output logic                 last
);
  localparam logic [PARAM_WID-1:0] ONE     = PARAM_WID'(1);
  localparam logic [PARAM_WID-1:0] OC0_MAX = PARAM_WID'(OC0 - 1);

  logic [PARAM_WID-1:0] oc0, ox0, oy0, oc1, ox1, oy1;
  logic m_oc0, m_ox0, m_oy0, m_oc1, m_ox1, m_oy1;
  logic c0, c1, c2, c3, c4;
  logic [ADDR_WID-1:0] ch, row, col;

  assign m_oc0 = (oc0 == OC0_MAX);
  assign m_ox0 = (ox0 == cfg_oy0 - ONE);
  assign m_oy0 = (oy0 == cfg_oy0 - ONE);
  assign m_oc1 = (oc1 == cfg_oc1 - ONE);
  assign m_ox1 = (ox1 == cfg_oy1 - ONE);
  assign m_oy1 = (oy1 == cfg_oy1 - ONE);

  // cN: every digit up to and including level N is at its max, so level N+1 steps
  assign c0   = m_oc0;
  assign c1   = c0 & m_ox0;
  assign c2   = c1 & m_oy0;
  assign c3   = c2 & m_oc1;
  assign c4   = c3 & m_ox1;
  assign last = c4 & m_oy1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      oc0 <= '0; ox0 <= '0; oy0 <= '0; oc1 <= '0; ox1 <= '0; oy1 <= '0;
    end else if (clear) begin
      oc0 <= '0; ox0 <= '0; oy0 <= '0; oc1 <= '0; ox1 <= '0; oy1 <= '0;
    end else if (adv) begin
      oc0 <= m_oc0 ? '0 : oc0 + ONE;
      if (c0) ox0 <= m_ox0 ? '0 : ox0 + ONE;
      if (c1) oy0 <= m_oy0 ? '0 : oy0 + ONE;
      if (c2) oc1 <= m_oc1 ? '0 : oc1 + ONE;
      if (c3) ox1 <= m_ox1 ? '0 : ox1 + ONE;
      if (c4) oy1 <= m_oy1 ? '0 : oy1 + ONE;
    end
  end

  assign ch   = ADDR_WID'(oc1) * ADDR_WID'(OC0) + ADDR_WID'(oc0);
  assign row  = ADDR_WID'(oy1) * ADDR_WID'(cfg_oy0) + ADDR_WID'(oy0);
  assign col  = ADDR_WID'(ox1) * ADDR_WID'(cfg_oy0) + ADDR_WID'(ox0);
  assign addr = ch * plane + row * oy + col;

endmodule

// File: rtl/ofmap_stream_writer.sv
// rtl/ofmap_stream_writer.sv - reorders tiled ofmap beats into linear SRAM writes
module ofmap_stream_writer
  import ofmap_writer_pkg::*;
#(
  parameter int OC0       = 4,
  parameter int PARAM_WID = 16,
  parameter int ADDR_WID  = 32
) (
  input logic                  clk,
  input logic                  rst_n,
  ofmap_stream_writer_if.slave bus
);
  state_t state, state_next;

  logic [PARAM_WID-1:0] cfg_oy1, cfg_oc1, cfg_oy0;
  logic [PARAM_WID-1:0] in_oy1, in_oc1, in_oy0;
  logic [ADDR_WID-1:0]  oy_q, plane_q, oy_next, addr;
  logic                 prod_ok, cfg_acc, cfg_zero, beat_acc, last;
  logic                 wen_q, done_q;
  logic [ADDR_WID-1:0]  waddr_q;
  logic [31:0]          wdata_q;

  assign in_oy1   = bus.params_dat[OY1_FIELD*PARAM_WID +: PARAM_WID];
  assign in_oc1   = bus.params_dat[OC1_FIELD*PARAM_WID +: PARAM_WID];
  assign in_oy0   = bus.params_dat[OY0_FIELD*PARAM_WID +: PARAM_WID];
  assign cfg_zero = (in_oy1 == '0) || (in_oc1 == '0) || (in_oy0 == '0);

  assign bus.params_rdy = (state == IDLE);
  assign bus.ofmap_rdy  = (state == STREAM) && prod_ok;
  assign bus.busy       = (state != IDLE);
  assign cfg_acc        = bus.params_vld && (state == IDLE);
  assign beat_acc       = bus.ofmap_vld && bus.ofmap_rdy;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (cfg_acc) state_next = cfg_zero ? DONE : STREAM;
      STREAM:  if (beat_acc && last) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // The first STREAM cycle only loads the derived products; beats start after.
  assign oy_next = ADDR_WID'(cfg_oy1) * ADDR_WID'(cfg_oy0);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cfg_oy1 <= '0; cfg_oc1 <= '0; cfg_oy0 <= '0;
      oy_q    <= '0; plane_q <= '0; prod_ok <= 1'b0;
    end else begin
      if (cfg_acc) begin
        cfg_oy1 <= in_oy1;
        cfg_oc1 <= in_oc1;
        cfg_oy0 <= in_oy0;
      end
      if (state == STREAM && !prod_ok) begin
        oy_q    <= oy_next;
        plane_q <= oy_next * oy_next;
      end
      prod_ok <= (state == STREAM) && (state_next == STREAM);
    end
  end

  ofmap_addr_gen #(
    .OC0       (OC0),
    .PARAM_WID (PARAM_WID),
    .ADDR_WID  (ADDR_WID)
  ) u_addr_gen (
    .clk     (clk),
    .rst_n   (rst_n),
    .clear   (cfg_acc),
    .adv     (beat_acc),
    .cfg_oy1 (cfg_oy1),
    .cfg_oc1 (cfg_oc1),
    .cfg_oy0 (cfg_oy0),
    .oy      (oy_q),
    .plane   (plane_q),
    .addr    (addr),
    .last    (last)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wen_q   <= 1'b0;
      waddr_q <= '0;
      wdata_q <= '0;
      done_q  <= 1'b0;
    end else begin
      wen_q  <= beat_acc;
      done_q <= (state != DONE) && (state_next == DONE);
      if (beat_acc) begin
        waddr_q <= addr;
        wdata_q <= bus.ofmap_dat;
      end
    end
  end

  assign bus.mem_wen    = wen_q;
  assign bus.mem_waddr  = waddr_q;
  assign bus.mem_wdata  = wdata_q;
  assign bus.layer_done = done_q;

endmodule

// File: tb/tb_ofmap_stream_writer.sv
// tb/tb_ofmap_stream_writer.sv - randomized scoreboard bench for ofmap_stream_writer
module tb_ofmap_stream_writer;
  localparam int OC0 = 4;
  localparam int PW  = 16;
  localparam int AW  = 32;

  typedef struct {
    logic [AW-1:0] a;
    logic [31:0]   d;
    bit            last;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  ofmap_stream_writer_if #(.PARAM_WID(PW), .ADDR_WID(AW)) bus ();

  ofmap_stream_writer #(.OC0(OC0), .PARAM_WID(PW), .ADDR_WID(AW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  exp_t        sbq[$];
  logic [AW-1:0] wlog[$];
  int          n_pass = 0;
  int          n_total = 0;
  int          done_cnt = 0;
  int          wr_cnt = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp) $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    else n_pass++;
  endtask

  // Reference: decode beat index k into tile digits by division, then linear address.
  function automatic logic [AW-1:0] ref_addr(input int k, input int oy1, input int oc1, input int oy0);
    int r, d_oc0, d_ox0, d_oy0, d_oc1, d_ox1, d_oy1, ch, y, x, oy;
    d_oc0 = k % OC0;  r = k / OC0;
    d_ox0 = r % oy0;  r = r / oy0;
    d_oy0 = r % oy0;  r = r / oy0;
    d_oc1 = r % oc1;  r = r / oc1;
    d_ox1 = r % oy1;  d_oy1 = r / oy1;
    ch = d_oc1 * OC0 + d_oc0;
    y  = d_oy1 * oy0 + d_oy0;
    x  = d_ox1 * oy0 + d_ox0;
    oy = oy1 * oy0;
    return AW'((ch * oy + y) * oy + x);
  endfunction

  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.layer_done) done_cnt++;
      if (bus.mem_wen) begin
        wr_cnt++;
        wlog.push_back(bus.mem_waddr);
        if (sbq.size() == 0) begin
          chk("unexpected_write", 64'(bus.mem_waddr), 64'hFFFF_FFFF_FFFF_FFFF);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("waddr", 64'(bus.mem_waddr), 64'(e.a));
          chk("wdata", 64'(bus.mem_wdata), 64'(e.d));
          chk("done_with_write", 64'(bus.layer_done), 64'(e.last));
        end
      end
    end
  end

  task automatic send_cfg(input int oy1, input int oc1, input int oy0, input bit hold);
    bit ok = 0;
    @(negedge clk);
    bus.params_dat = {PW'(oy1), PW'(oc1), PW'(oy0)};
    bus.params_vld = 1'b1;
    for (int i = 0; i < 20 && !ok; i++) begin
      if (bus.params_rdy) ok = 1;
      @(negedge clk);
    end
    chk("cfg_accept", 64'(ok), 64'd1);
    if (hold) bus.params_dat = {PW'(5), PW'(5), PW'(5)};
    else bus.params_vld = 1'b0;
  endtask

  // mode: 0 random gaps, 1 valid every third cycle, 2 always valid
  task automatic run_layer(input int oy1, input int oc1, input int oy0, input int mode,
                           input int limit, input bit seqdata, input bit hold);
    int total, goal, k, cyc, d0;
    bit v;
    exp_t e;
    total = oy1 * oy1 * oc1 * oy0 * oy0 * OC0;
    goal  = (limit < total) ? limit : total;
    d0    = done_cnt;
    send_cfg(oy1, oc1, oy0, hold);
    k = 0;
    cyc = 0;
    while (k < goal && cyc < 5000) begin
      if (hold) begin
        if (k < 3) chk("params_rdy_in_stream", 64'(bus.params_rdy), 64'd0);
        else bus.params_vld = 1'b0;
      end
      case (mode)
        0:       v = ($urandom % 4) != 0;
        1:       v = (cyc % 3) == 0;
        default: v = 1'b1;
      endcase
      bus.ofmap_vld = v;
      bus.ofmap_dat = seqdata ? 32'hA0 + 32'(k) : $urandom;
      if (v && bus.ofmap_rdy) begin
        e.a = ref_addr(k, oy1, oc1, oy0);
        e.d = bus.ofmap_dat;
        e.last = (k == total - 1);
        sbq.push_back(e);
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    bus.ofmap_vld = 1'b0;
    bus.params_vld = 1'b0;
    chk("beats_accepted", 64'(k), 64'(goal));
    for (int i = 0; i < 10 && sbq.size() != 0; i++) @(negedge clk);
    chk("scoreboard_drained", 64'(sbq.size()), 64'd0);
    if (goal == total) begin
      @(negedge clk);
      chk("layer_done_count", 64'(done_cnt - d0), 64'd1);
    end
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_params_rdy"}, 64'(bus.params_rdy), 64'd1);
    chk({tag, "_ofmap_rdy"},  64'(bus.ofmap_rdy),  64'd0);
    chk({tag, "_mem_wen"},    64'(bus.mem_wen),    64'd0);
    chk({tag, "_mem_waddr"},  64'(bus.mem_waddr),  64'd0);
    chk({tag, "_mem_wdata"},  64'(bus.mem_wdata),  64'd0);
    chk({tag, "_layer_done"}, 64'(bus.layer_done), 64'd0);
    chk({tag, "_busy"},       64'(bus.busy),       64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int w0, d0;
    bit seen [64];
    logic [AW-1:0] first9 [9];
    first9 = '{0, 16, 32, 48, 1, 17, 33, 49, 4};
    bus.params_dat = '0;
    bus.params_vld = 1'b0;
    bus.ofmap_dat  = '0;
    bus.ofmap_vld  = 1'b0;
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    rst_n = 1'b1;

    // minimal layer, sequential data
    run_layer(1, 1, 1, 2, 1000, 1, 0);

    // tiled layer with random gaps, then the spec-listed address points
    wlog.delete();
    run_layer(2, 1, 2, 0, 1000, 0, 0);
    chk("tiled_write_count", 64'(wlog.size()), 64'd64);
    if (wlog.size() == 64) begin
      for (int i = 0; i < 9; i++) chk("tiled_addr_point", 64'(wlog[i]), 64'(first9[i]));
      chk("tiled_last_addr", 64'(wlog[63]), 64'd63);
      for (int i = 0; i < 64; i++) seen[i] = 0;
      for (int i = 0; i < 64; i++) if (wlog[i] < 64) seen[wlog[i]] = 1;
      for (int i = 0; i < 64; i++) chk("tiled_addr_covered", 64'(seen[i]), 64'd1);
    end

    // backpressure: valid every third cycle
    wlog.delete();
    run_layer(2, 1, 2, 1, 1000, 0, 0);
    chk("bp_write_count", 64'(wlog.size()), 64'd64);

    // multi-channel with params_vld held during STREAM
    run_layer(1, 2, 1, 2, 1000, 0, 1);

    // zero-size config
    w0 = wr_cnt;
    d0 = done_cnt;
    send_cfg(0, 3, 2, 0);
    chk("zero_cfg_done_next_cycle", 64'(bus.layer_done), 64'd1);
    repeat (4) @(negedge clk);
    chk("zero_cfg_no_writes", 64'(wr_cnt - w0), 64'd0);
    chk("zero_cfg_done_count", 64'(done_cnt - d0), 64'd1);

    // reset after 10 beats of a tiled layer
    d0 = done_cnt;
    run_layer(2, 1, 2, 2, 10, 0, 0);
    chk("pre_reset_busy", 64'(bus.busy), 64'd1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_reset_outputs("midreset");
    sbq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    chk("aborted_no_done", 64'(done_cnt - d0), 64'd0);
    run_layer(1, 1, 1, 0, 1000, 0, 0);

    // random small configs
    for (int t = 0; t < 4; t++)
      run_layer(int'($urandom_range(1, 2)), int'($urandom_range(1, 3)),
                int'($urandom_range(1, 3)), 0, 1000, 0, 0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
